// File: rtl/gate_identifier.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gate_identifier
//
// Sequential tester for a two-input combinational gate. A sweep drives the
// four {a,b} vectors 00, 01, 10, 11. Each vector is held for SETTLE_CYCLES
// clocks, and the gate output is sampled on the last edge of that window.
// The captured 4-bit truth table is then classified as one of the seven
// basic functions.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..255)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        sweep request, sampled only while idle
//   dut_out      output of the gate under test
//   drive_a/b    registered inputs to the gate under test
//   busy         high while a sweep is in progress
//   done         one-cycle pulse when a sweep completes
//   truth_table  bit i = dut_out captured for {a,b} = i
//   gate_id      1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 NOT a, 0 unknown
//   match        truth_table is one of the seven known functions
//
// truth_table, gate_id and match are loaded on the edge that raises done.
// They hold until the next done, so starting a new sweep leaves the previous
// result visible.
// ---------------------------------------------------------------------------
module gate_identifier #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       drive_a,
  output logic       drive_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_id,
  output logic       match
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t     state;
  logic [1:0] idx;      // current vector; drive_a = idx[1], drive_b = idx[0]
  logic [7:0] cnt;      // settle counter within the current vector
  logic [3:0] tt;       // shadow truth table filled during the sweep

  logic       last_sample;
  logic [3:0] tt_final;
  logic [2:0] id_next;
  logic       match_next;

  assign last_sample = (cnt == CNT_LAST);

  // Bit 3 has not been written to the shadow register yet on the final
  // edge. Take it straight from dut_out so the result is loaded on that
  // same edge.
  assign tt_final = {dut_out, tt[2:0]};

  always_comb begin
    id_next    = 3'd0;
    match_next = 1'b1;
    case (tt_final)
      4'b1000: id_next = 3'd1;  // AND
      4'b1110: id_next = 3'd2;  // OR
      4'b0111: id_next = 3'd3;  // NAND
      4'b0001: id_next = 3'd4;  // NOR
      4'b0110: id_next = 3'd5;  // XOR
      4'b1001: id_next = 3'd6;  // XNOR
      4'b0011: id_next = 3'd7;  // NOT a
      default: match_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= 8'd0;
      tt          <= 4'd0;
      drive_a     <= 1'b0;
      drive_b     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 4'd0;
      gate_id     <= 3'd0;
      match       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SWEEP;
            idx     <= 2'd0;
            cnt     <= 8'd0;
            drive_a <= 1'b0;
            drive_b <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SWEEP: begin
          if (last_sample) begin
            tt[idx] <= dut_out;
            cnt     <= 8'd0;
            if (idx != 2'd3) begin
              idx                <= idx + 2'd1;
              {drive_a, drive_b} <= idx + 2'd1;
            end else begin
              state       <= DONE;
              idx         <= 2'd0;
              drive_a     <= 1'b0;
              drive_b     <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              truth_table <= tt_final;
              gate_id     <= id_next;
              match       <= match_next;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // One-cycle completion state. start is not looked at here, so
        // back-to-back sweeps always get one IDLE cycle between them.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_identifier.sv
`timescale 1ns/1ps
module tb_gate_identifier;

  typedef struct packed {
    logic [3:0] tt;
    logic [2:0] id;
    logic       m;
  } res_t;

  typedef struct {
    int         f;
    logic [3:0] tt;
    logic [2:0] id;
    logic       m;
  } vec_t;

  logic clk, rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // main instance, SETTLE_CYCLES = 2
  logic start, dut_out, drive_a, drive_b, busy, done, match;
  logic [3:0] truth_table;
  logic [2:0] gate_id;
  int fn = 0;

  // auxiliary instances: S=1 (AND), S=3 (XOR with 2-cycle lag), S=255 (AND)
  logic start1, out1, da1, db1, busy1, done1, m1;
  logic [3:0] tt1; logic [2:0] id1;
  logic start3, out3, da3, db3, busy3, done3, m3;
  logic [3:0] tt3; logic [2:0] id3;
  logic start255, out255, da255, db255, busy255, done255, m255;
  logic [3:0] tt255; logic [2:0] id255;
  logic [1:0] lag1, lag2;

  res_t q[$], q1[$], q3[$], q255[$];

  function automatic logic gate_fn(input int f, input logic a, input logic b);
    case (f)
      1: return a & b;
      2: return a | b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      6: return ~(a ^ b);
      7: return ~a;
      9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign dut_out = gate_fn(fn, drive_a, drive_b);
  assign out1    = gate_fn(1, da1, db1);
  assign out255  = gate_fn(1, da255, db255);
  assign out3    = gate_fn(5, lag2[1], lag2[0]);

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    lag1 <= {da3, db3};
    lag2 <= lag1;
  end

  initial clk = 0;
  always #5 clk = ~clk;

  gate_identifier #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .drive_a(drive_a), .drive_b(drive_b), .busy(busy), .done(done),
    .truth_table(truth_table), .gate_id(gate_id), .match(match));

  gate_identifier #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(out1),
    .drive_a(da1), .drive_b(db1), .busy(busy1), .done(done1),
    .truth_table(tt1), .gate_id(id1), .match(m1));

  gate_identifier #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .dut_out(out3),
    .drive_a(da3), .drive_b(db3), .busy(busy3), .done(done3),
    .truth_table(tt3), .gate_id(id3), .match(m3));

  gate_identifier #(.SETTLE_CYCLES(255)) u255 (
    .clk(clk), .rst_n(rst_n), .start(start255), .dut_out(out255),
    .drive_a(da255), .drive_b(db255), .busy(busy255), .done(done255),
    .truth_table(tt255), .gate_id(id255), .match(m255));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: done seen with no expected result queued", nm);
  endtask

  task automatic cmp_res(input string nm, input res_t e, input logic [3:0] tt,
                         input logic [2:0] id, input logic m);
    chk({nm, "_truth_table"}, 32'(tt), 32'(e.tt));
    chk({nm, "_gate_id"}, 32'(id), 32'(e.id));
    chk({nm, "_match"}, 32'(m), 32'(e.m));
  endtask

  // Scoreboard monitors: pop an expectation whenever an instance pulses done.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) fail_now("main_unexpected_done");
      else cmp_res("main", q.pop_front(), truth_table, gate_id, match);
    end
    if (done1) begin
      if (q1.size() == 0) fail_now("s1_unexpected_done");
      else cmp_res("s1", q1.pop_front(), tt1, id1, m1);
    end
    if (done3) begin
      if (q3.size() == 0) fail_now("s3_unexpected_done");
      else cmp_res("s3", q3.pop_front(), tt3, id3, m3);
    end
    if (done255) begin
      if (q255.size() == 0) fail_now("s255_unexpected_done");
      else cmp_res("s255", q255.pop_front(), tt255, id255, m255);
    end
  end

  // One sweep on the main instance. Checks latency, busy span and drive order.
  // With poke set, start is also pulsed during SWEEP and during DONE.
  task automatic run_sweep(input int f, input logic [3:0] tt, input logic [2:0] id,
                           input logic m, input bit poke);
    int lat, bc;
    bit got;
    logic [15:0] seq;
    @(negedge clk);
    fn = f;
    start = 1;
    q.push_back('{tt, id, m});
    @(negedge clk);            // start accepted on the edge just passed
    start = 0;
    lat = 0; bc = 0; got = 0; seq = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done) got = 1;
      else begin
        if (busy) bc++;
        seq = {seq[13:0], drive_a, drive_b};
        start = (poke && lat == 3);
        @(negedge clk);
        lat++;
      end
    end
    start = 0;
    chk($sformatf("f%0d_done_seen", f), 32'(got), 1);
    chk($sformatf("f%0d_latency", f), 32'(lat), 8);
    chk($sformatf("f%0d_busy_span", f), 32'(bc), 8);
    chk($sformatf("f%0d_drive_order", f), 32'(seq), 32'h05AF);
    if (poke) begin
      start = 1;               // currently in DONE
      @(negedge clk);
      start = 0;
      @(negedge clk);
      chk("start_in_done_ignored", 32'(busy), 0);
    end else begin
      @(negedge clk);
    end
  endtask

  function automatic logic aux_done(input int w);
    case (w)
      1: return done1;
      3: return done3;
      default: return done255;
    endcase
  endfunction

  task automatic aux_sweep(input int w, input int exp_lat, input int limit);
    int lat;
    bit got;
    @(negedge clk);
    case (w)
      1: begin start1 = 1; q1.push_back('{4'b1000, 3'd1, 1'b1}); end
      3: begin start3 = 1; q3.push_back('{4'b0110, 3'd5, 1'b1}); end
      default: begin start255 = 1; q255.push_back('{4'b1000, 3'd1, 1'b1}); end
    endcase
    @(negedge clk);
    start1 = 0; start3 = 0; start255 = 0;
    lat = 0; got = 0;
    for (int k = 0; k < limit && !got; k++) begin
      if (aux_done(w)) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk($sformatf("s%0d_done_seen", w), 32'(got), 1);
    chk($sformatf("s%0d_latency", w), 32'(lat), 32'(exp_lat));
    @(negedge clk);
  endtask

  vec_t vecs[9] = '{
    '{1, 4'b1000, 3'd1, 1'b1},
    '{2, 4'b1110, 3'd2, 1'b1},
    '{3, 4'b0111, 3'd3, 1'b1},
    '{4, 4'b0001, 3'd4, 1'b1},
    '{5, 4'b0110, 3'd5, 1'b1},
    '{6, 4'b1001, 3'd6, 1'b1},
    '{7, 4'b0011, 3'd7, 1'b1},
    '{8, 4'b0000, 3'd0, 1'b0},
    '{9, 4'b1111, 3'd0, 1'b0}
  };

  initial begin
    int  t1, t2;
    bit  got, held;
    rst_n = 0; start = 0; start1 = 0; start3 = 0; start255 = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({busy, done, drive_a, drive_b, truth_table, gate_id, match}), 0);
    rst_n = 1;

    foreach (vecs[i]) run_sweep(vecs[i].f, vecs[i].tt, vecs[i].id, vecs[i].m, i == 3);

    // Reset in the middle of a sweep, once vector 10 is being driven.
    @(negedge clk);
    fn = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("mid_sweep_at_idx2", 32'({drive_a, drive_b}), 32'h2);
    rst_n = 0;
    #1;
    chk("mid_sweep_reset_outputs",
        32'({busy, done, drive_a, drive_b, truth_table, gate_id, match}), 0);
    repeat (12) @(negedge clk);   // any done here is flagged by the monitor
    rst_n = 1;
    run_sweep(5, 4'b0110, 3'd5, 1'b1, 1'b0);

    // Back-to-back sweeps with start held high: NAND, then NOR.
    @(negedge clk);
    fn = 3;
    start = 1;
    q.push_back('{4'b0111, 3'd3, 1'b1});
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("b2b_first_done", 32'(got), 1);
    t1 = cyc;
    fn = 4;
    q.push_back('{4'b0001, 3'd4, 1'b1});
    held = 1;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (gate_id != 3'd3) held = 0;
    end
    t2 = cyc;
    start = 0;
    chk("b2b_second_done", 32'(got), 1);
    chk("b2b_period", 32'(t2 - t1), 10);
    chk("b2b_result_held", 32'(held), 1);
    repeat (2) @(negedge clk);

    aux_sweep(1, 4, 40);
    aux_sweep(3, 12, 60);
    aux_sweep(255, 1020, 1100);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size() + q1.size() + q3.size() + q255.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_identifier.md
# gate_identifier

Sequential tester that drives a two-input combinational gate under test through all four input combinations, samples its single output after a settle delay, and classifies the captured truth table as one of the seven basic functions (AND, OR, NAND, NOR, XOR, XNOR, NOT a). It is the consumer side of the lab's gate bank: it drives the gate's `a`/`b` inputs and reads back one of its outputs. It also serves as an on-board self-check for the NAND-built gate set.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 2, clock cycles each input vector is held before `dut_out` is sampled; legal range 1..255.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  sweep request; sampled only in IDLE.
- `dut_out`  input  1  output of the gate under test.
- `drive_a`  output  1  registered `a` input to the gate under test.
- `drive_b`  output  1  registered `b` input to the gate under test.
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  one-cycle pulse when a sweep completes.
- `truth_table`  output  4  captured responses; bit i = `dut_out` for {a,b}=i.
- `gate_id`  output  3  classification code; valid from the `done` pulse onward.
- `match`  output  1  1 when `truth_table` equals a known function.

## Operation

- **States:** IDLE, SWEEP, DONE.
  - IDLE: `start`=1 → SWEEP. Same edge: {`drive_a`,`drive_b`}=00, vector index idx=0, settle counter cnt=0, `busy`=1.
  - SWEEP: cnt increments each edge.
  - On the edge where cnt==SETTLE_CYCLES-1:
    - `dut_out` is captured into shadow bit tt[idx].
    - cnt is cleared.
    - If idx<3: idx increments and {`drive_a`,`drive_b`} takes the new idx value.
    - If idx==3: go to DONE. Same edge: drive returns to 00, `busy`=0, `done`=1, and `truth_table`, `gate_id` and `match` are loaded from the complete 4-bit shadow value.
  - DONE: lasts exactly one cycle, then → IDLE with `done`=0. `start` asserted during DONE is ignored.
- **Vector order:** idx 0..3 = {a,b} = 00, 01, 10, 11. `drive_a`=idx[1], `drive_b`=idx[0].
- **Classification** (`truth_table` → `gate_id`, `match`=1):
  - 1000 → 1 (AND)
  - 1110 → 2 (OR)
  - 0111 → 3 (NAND)
  - 0001 → 4 (NOR)
  - 0110 → 5 (XOR)
  - 1001 → 6 (XNOR)
  - 0011 → 7 (NOT a)
  - any other pattern → `gate_id`=0, `match`=0.
- **Result hold:** `truth_table`, `gate_id` and `match` hold their values until the next `done`. Starting a new sweep does not clear them.
- **Start handling:** `start` in SWEEP is ignored; there is no queuing. `start` may stay high continuously, which gives back-to-back sweeps with a single IDLE cycle between them.
- **Counter width:** cnt is 8 bits; cnt never exceeds SETTLE_CYCLES-1.

## Timing

- **Reset (`rst_n`=0, asynchronous):**
  - State=IDLE.
  - `drive_a`=`drive_b`=0.
  - `busy`=0, `done`=0.
  - `truth_table`=0000, `gate_id`=0, `match`=0.
  - idx=0, cnt=0, shadow tt cleared.
- **Reset mid-sweep:** aborts immediately to the values above; no `done` is produced. Release is synchronous to the next edge.
- **Vector hold:** each vector is driven for exactly SETTLE_CYCLES cycles. `dut_out` is sampled on the last edge of that window.
- **Latency:** for `start` accepted at edge E0, `done` is high in the cycle following edge E0+4·SETTLE_CYCLES. With SETTLE_CYCLES=2, `done` is asserted after E0+8.
- **Busy span:** `busy` is high for exactly 4·SETTLE_CYCLES cycles per sweep.
- **Back-to-back period:** start-to-start is 4·SETTLE_CYCLES+2 cycles.
- **No combinational paths:** none from inputs to outputs; all outputs are registered.

## Test plan

- **AND model, SETTLE_CYCLES=2:** `dut_out`=a&b, pulse `start` → `truth_table`=1000, `gate_id`=1, `match`=1. `done` rises after exactly 8 edges; `busy` is high for 8 cycles.
- **All seven functions:** sweep each of OR, NAND, NOR, XOR, XNOR, NOT a → `gate_id` 2..7, `match`=1. Drive order observed as 00, 01, 10, 11, each vector held 2 cycles.
- **Unknown patterns:** constant 0 → `truth_table`=0000, `gate_id`=0, `match`=0. Constant 1 → 1111, `gate_id`=0, `match`=0.
- **Reset and start-ignore:** assert `rst_n`=0 mid-sweep at idx=2 → all outputs return to reset values at once and no `done` appears. Restart with XOR → `gate_id`=5. Also check that `start` pulses during SWEEP and during DONE do not change timing.
- **Back-to-back with retained results:** hold `start`=1 with NAND then switch the model to NOR → two sweeps 10 cycles apart. `gate_id` holds 3 through the second sweep, then becomes 4.
- **SETTLE_CYCLES=1 and 255:** latency is 4 and 1020 cycles respectively. With SETTLE_CYCLES=3 and a model whose output lags its inputs by 2 cycles, XOR is still classified correctly (`gate_id`=5).
